mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the CPU core and the AXI4-Lite memory slave. It takes two simple request ports, serialises them onto one AXI4-Lite master interface with at most one transaction in flight, and returns completion pulses and read data. Port 1 is the instruction-fetch port and is read-only. Port 2 is the load/store port and can read or write. The block sits in the CPU top level between the core and the SRAM model.

## Interface
- Clock `clk`; reset `rst` is asynchronous and active-low.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MASK_W`, default 4: byte-mask width, equal to `DATA_W/8`.
- `clk` in, 1: clock. All logic is rising-edge.
- `rst` in, 1: asynchronous, active-low reset.
- `mem_1_addr` in, ADDR_W: fetch address.
- `mem_1_r_en` in, 1: fetch request, one-cycle pulse.
- `mem_1_r` out, DATA_W: fetched word.
- `mem_1_finish` out, 1: fetch-done pulse.
- `mem_2_addr` in, ADDR_W: load/store byte address.
- `mem_2_w` in, DATA_W: store data, right-aligned (unshifted).
- `mem_2_mask` in, MASK_W: store byte mask, right-aligned. Legal values are 0001, 0011 and 1111.
- `mem_2_r_en` / `mem_2_w_en` in, 1: load / store request, one-cycle pulse.
- `mem_2_r` out, DATA_W: load word, shifted right by the byte offset.
- `mem_2_finish` out, 1: load/store-done pulse.
- AXI read channels, AXI4-Lite master side:
  - `axi_araddr` out, ADDR_W; `axi_arvalid` out; `axi_arready` in.
  - `axi_rdata` in, DATA_W; `axi_rresp` in, 2; `axi_rvalid` in; `axi_rready` out.
- AXI write channels, AXI4-Lite master side:
  - `axi_awaddr` out, ADDR_W; `axi_awvalid` out; `axi_awready` in.
  - `axi_wdata` out, DATA_W; `axi_wstrb` out, MASK_W; `axi_wvalid` out; `axi_wready` in.
  - `axi_bresp` in, 2; `axi_bvalid` in; `axi_bready` out.

## Operation
- **Request capture.** A request pulse is latched into a per-port pending slot (address, data, mask, kind) on the edge where it is sampled, regardless of FSM state. There is one slot per port. A new pulse on a port whose slot is still pending overwrites the slot; this is a core protocol violation.
- **Store vs load on port 2.** `mem_2_w_en` and `mem_2_r_en` together: the store wins and the load is dropped.
- **Arbitration.** Fixed priority in IDLE: port 2 pending first, then port 1.
- **FSM states:** IDLE, AR, R, AW, B, DONE.
  - IDLE → AR when a read is selected.
  - IDLE → AW when a store is selected.
- **AR.** `axi_arvalid` = 1 and `axi_araddr` = latched address. On `arvalid && arready`, go to R.
- **R.** `axi_rready` = 1. On `rvalid && rready`, register the data into the selected port's read register, then go to DONE.
  - Port 1 data is passed unmodified.
  - Port 2 data is `rdata >> (8*addr[1:0])`; sign/zero extension is the core's job.
- **AW.** `axi_awvalid` and `axi_wvalid` rise together.
  - `axi_awaddr` = addr.
  - `axi_wdata` = `w << (8*addr[1:0])`.
  - `axi_wstrb` = `mask << addr[1:0]`, truncated to MASK_W.
  - Each valid drops independently after its own handshake. Go to B once both handshakes are done (same cycle or different cycles).
- **B.** `axi_bready` = 1. On `bvalid`, go to DONE.
- **DONE.** The finish line of the served port is high for exactly one cycle, then go to IDLE.
- **Read-data hold.** `mem_1_r` / `mem_2_r` hold their value until that port's next read completes.
- **Responses.** `rresp` / `bresp` values other than OKAY do not alter flow; the transaction completes normally.
- **Misaligned addresses.** No checking is done; lanes shifted past the word are dropped.

## Timing
- **Reset value.** While `rst` = 0 (asynchronous):
  - All outputs are 0.
  - State is IDLE.
  - Pending slots and read registers are cleared.
- **Reset mid-transaction.** All valid/ready outputs drop immediately and the transaction is abandoned with no finish pulse.
- **Minimum read latency** (slave `arready` = 1 and `rvalid` in the first R cycle):
  - Request sampled at edge 0.
  - `arvalid` in cycle 1.
  - `rready` in cycle 2.
  - finish in cycle 3.
- **Minimum write latency:**
  - Request sampled at edge 0.
  - aw/w valid in cycle 1.
  - `bready` in cycle 2.
  - finish in cycle 3.
- **AXI valid stability.** A valid output, once raised, is never lowered before its handshake, and its payload is stable while valid is high.
- **No overlap.** At most one outstanding AXI transaction. Read and write channels are never active in the same cycle.
- **Both ports pending.** Port 2 is served fully (through DONE) before port 1 starts in the following IDLE cycle.

## Structure
- Shared package holds:
  - width constants: ISA width 32, mask width 4;
  - AXI response codes OKAY = 2'b00 and SLVERR = 2'b10;
  - the FSM state enum.
- The package is also used by core and SRAM.
- One natural sub-module, `mem_lane_align`: combinational byte-lane shifter (wdata/wstrb left shift, rdata right shift by `addr[1:0]`).

## Test plan
- Fetch `mem_1_addr`=0x80000000 with slave returning 0x00000413 at zero wait → `mem_1_r`=0x00000413 and `mem_1_finish` pulses in cycle 3.
- Byte store: `mem_2_addr`=0x80000103, `mem_2_w`=0x000000AB, mask 0001 → `wdata`=0xAB000000, `wstrb`=1000; `mem_2_finish` pulses one cycle after `bvalid`.
- Halfword load at 0x80000102, slave `rdata`=0xBEEF1234 with `arready` delayed 3 cycles → `arvalid` held stable for 3 cycles, then `mem_2_r`=0x0000BEEF.
- Same-cycle `mem_1_r_en` and `mem_2_w_en` → the AXI write completes and `mem_2_finish` pulses first, then the fetch runs and `mem_1_finish` pulses.
- `awready` delayed 2 cycles relative to `wready` → `wvalid` drops after its handshake, `awvalid` stays high; B entered only after both handshakes.
- `rst` driven 0 while in R → `rready` goes 0 immediately, no finish pulse, and the FSM restarts from IDLE after release.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the CPU memory path: widths, AXI response codes
// and the memory-controller FSM state encoding.
package mem_ctrl_pkg;

    localparam int ISA_WIDTH  = 32;
    localparam int MASK_WIDTH = 4;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } mem_state_e;

endpackage

// File: rtl/mem_ctrl_lane_align.sv
// Combinational byte-lane shifter: moves store data/mask up to the addressed
// byte lane and brings load data down from it. Lanes pushed past the word are lost.
module mem_lane_align #(
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) (
    input  logic [1:0]        i_off,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [MASK_W-1:0] i_mask,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_wdata,
    output logic [MASK_W-1:0] o_wstrb,
    output logic [DATA_W-1:0] o_rdata
);

    logic [4:0] w_bit_sh;

    assign w_bit_sh = {i_off, 3'b000};
    assign o_wdata  = i_wdata << w_bit_sh;
    assign o_wstrb  = i_mask << i_off;
    assign o_rdata  = i_rdata >> w_bit_sh;

endmodule

// File: rtl/mem_ctrl.sv
// Serialises the fetch port and the load/store port onto a single AXI4-Lite
// master with one transaction in flight; port 2 has fixed priority.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = ISA_WIDTH,
    parameter int MASK_W = MASK_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_1_addr,
    input  logic              mem_1_r_en,
    output logic [DATA_W-1:0] mem_1_r,
    output logic              mem_1_finish,
    input  logic [ADDR_W-1:0] mem_2_addr,
    input  logic [DATA_W-1:0] mem_2_w,
    input  logic [MASK_W-1:0] mem_2_mask,
    input  logic              mem_2_r_en,
    input  logic              mem_2_w_en,
    output logic [DATA_W-1:0] mem_2_r,
    output logic              mem_2_finish,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    output logic [ADDR_W-1:0] axi_awaddr,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [DATA_W-1:0] axi_wdata,
    output logic [MASK_W-1:0] axi_wstrb,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_bready,
    output mem_state_e        dbg_state,
    output logic              dbg_resp_err
);

    // AXI handshake rule: a transfer occurs on the rising edge where valid and
    // ready are both high; valid and its payload are held until that edge.

    mem_state_e        r_state;
    logic              r_p1_pend;
    logic [ADDR_W-1:0] r_p1_addr;
    logic              r_p2_pend;
    logic              r_p2_we;
    logic [ADDR_W-1:0] r_p2_addr;
    logic [DATA_W-1:0] r_p2_wdata;
    logic [MASK_W-1:0] r_p2_mask;

    logic              r_act_p2;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_arvalid;
    logic              r_rready;
    logic [ADDR_W-1:0] r_awaddr;
    logic              r_awvalid;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wstrb;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_fin1;
    logic              r_fin2;
    logic [DATA_W-1:0] r_mem_1_r;
    logic [DATA_W-1:0] r_mem_2_r;
    logic              r_resp_err;

    logic              w_take_1;
    logic              w_take_2;
    logic [1:0]        w_off;
    logic [DATA_W-1:0] w_al_wdata;
    logic [MASK_W-1:0] w_al_wstrb;
    logic [DATA_W-1:0] w_al_rdata;
    logic              w_aw_done;
    logic              w_w_done;

    assign w_take_2  = (r_state == ST_IDLE) && r_p2_pend;
    assign w_take_1  = (r_state == ST_IDLE) && !r_p2_pend && r_p1_pend;
    // Stores are shifted while leaving IDLE; loads are shifted with the held read address.
    assign w_off     = (r_state == ST_IDLE) ? r_p2_addr[1:0] : r_araddr[1:0];
    assign w_aw_done = !r_awvalid || axi_awready;
    assign w_w_done  = !r_wvalid || axi_wready;

    mem_lane_align #(
        .DATA_W (DATA_W),
        .MASK_W (MASK_W)
    ) u_align (
        .i_off   (w_off),
        .i_wdata (r_p2_wdata),
        .i_mask  (r_p2_mask),
        .i_rdata (axi_rdata),
        .o_wdata (w_al_wdata),
        .o_wstrb (w_al_wstrb),
        .o_rdata (w_al_rdata)
    );

    // A pulse arriving on the same edge the slot is taken re-arms the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1_pend  <= 1'b0;
            r_p1_addr  <= '0;
            r_p2_pend  <= 1'b0;
            r_p2_we    <= 1'b0;
            r_p2_addr  <= '0;
            r_p2_wdata <= '0;
            r_p2_mask  <= '0;
        end else begin
            if (mem_1_r_en) begin
                r_p1_pend <= 1'b1;
                r_p1_addr <= mem_1_addr;
            end else if (w_take_1) begin
                r_p1_pend <= 1'b0;
            end
            if (mem_2_w_en) begin
                r_p2_pend  <= 1'b1;
                r_p2_we    <= 1'b1;
                r_p2_addr  <= mem_2_addr;
                r_p2_wdata <= mem_2_w;
                r_p2_mask  <= mem_2_mask;
            end else if (mem_2_r_en) begin
                r_p2_pend <= 1'b1;
                r_p2_we   <= 1'b0;
                r_p2_addr <= mem_2_addr;
            end else if (w_take_2) begin
                r_p2_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_act_p2   <= 1'b0;
            r_araddr   <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_awaddr   <= '0;
            r_awvalid  <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_fin1     <= 1'b0;
            r_fin2     <= 1'b0;
            r_mem_1_r  <= '0;
            r_mem_2_r  <= '0;
            r_resp_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take_2) begin
                        r_act_p2 <= 1'b1;
                        if (r_p2_we) begin
                            r_awaddr  <= r_p2_addr;
                            r_wdata   <= w_al_wdata;
                            r_wstrb   <= w_al_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_AW;
                        end else begin
                            r_araddr  <= r_p2_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end
                    end else if (w_take_1) begin
                        r_act_p2  <= 1'b0;
                        r_araddr  <= r_p1_addr;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (axi_rvalid) begin
                        r_rready <= 1'b0;
                        if (r_act_p2) begin
                            r_mem_2_r <= w_al_rdata;
                            r_fin2    <= 1'b1;
                        end else begin
                            r_mem_1_r <= axi_rdata;
                            r_fin1    <= 1'b1;
                        end
                        if (axi_rresp != AXI_OKAY) r_resp_err <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_AW: begin
                    if (axi_awready) r_awvalid <= 1'b0;
                    if (axi_wready) r_wvalid <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (axi_bvalid) begin
                        r_bready <= 1'b0;
                        r_fin2   <= r_act_p2;
                        r_fin1   <= !r_act_p2;
                        if (axi_bresp != AXI_OKAY) r_resp_err <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_fin1  <= 1'b0;
                    r_fin2  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign axi_araddr   = r_araddr;
    assign axi_arvalid  = r_arvalid;
    assign axi_rready   = r_rready;
    assign axi_awaddr   = r_awaddr;
    assign axi_awvalid  = r_awvalid;
    assign axi_wdata    = r_wdata;
    assign axi_wstrb    = r_wstrb;
    assign axi_wvalid   = r_wvalid;
    assign axi_bready   = r_bready;
    assign mem_1_r      = r_mem_1_r;
    assign mem_1_finish = r_fin1;
    assign mem_2_r      = r_mem_2_r;
    assign mem_2_finish = r_fin2;
    assign dbg_state    = r_state;
    assign dbg_resp_err = r_resp_err;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: an AXI4-Lite slave with programmable delays,
// a transaction-level expectation model and a per-cycle compare process.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] mem_1_addr;
  logic        mem_1_r_en;
  logic [31:0] mem_1_r;
  logic        mem_1_finish;
  logic [31:0] mem_2_addr;
  logic [31:0] mem_2_w;
  logic [3:0]  mem_2_mask;
  logic        mem_2_r_en;
  logic        mem_2_w_en;
  logic [31:0] mem_2_r;
  logic        mem_2_finish;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  mem_state_e  dbg_state;
  logic        dbg_resp_err;

  mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_1_addr   (mem_1_addr),
    .mem_1_r_en   (mem_1_r_en),
    .mem_1_r      (mem_1_r),
    .mem_1_finish (mem_1_finish),
    .mem_2_addr   (mem_2_addr),
    .mem_2_w      (mem_2_w),
    .mem_2_mask   (mem_2_mask),
    .mem_2_r_en   (mem_2_r_en),
    .mem_2_w_en   (mem_2_w_en),
    .mem_2_r      (mem_2_r),
    .mem_2_finish (mem_2_finish),
    .axi_araddr   (axi_araddr),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_rdata    (axi_rdata),
    .axi_rresp    (axi_rresp),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .axi_awaddr   (axi_awaddr),
    .axi_awvalid  (axi_awvalid),
    .axi_awready  (axi_awready),
    .axi_wdata    (axi_wdata),
    .axi_wstrb    (axi_wstrb),
    .axi_wvalid   (axi_wvalid),
    .axi_wready   (axi_wready),
    .axi_bresp    (axi_bresp),
    .axi_bvalid   (axi_bvalid),
    .axi_bready   (axi_bready),
    .dbg_state    (dbg_state),
    .dbg_resp_err (dbg_resp_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks_total = 0;
  int checks_pass  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // ---------------- AXI slave ----------------
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] slave_rdata = '0;
  logic [1:0]  slave_resp = AXI_OKAY;

  initial begin
    axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (axi_arvalid) begin axi_arready = (ar_cnt == ar_delay); ar_cnt++; end
      else begin axi_arready = 0; ar_cnt = 0; end
      if (axi_rready) begin axi_rvalid = (r_cnt == r_delay); r_cnt++; end
      else begin axi_rvalid = 0; r_cnt = 0; end
      if (axi_awvalid) begin axi_awready = (aw_cnt == aw_delay); aw_cnt++; end
      else begin axi_awready = 0; aw_cnt = 0; end
      if (axi_wvalid) begin axi_wready = (w_cnt == w_delay); w_cnt++; end
      else begin axi_wready = 0; w_cnt = 0; end
      if (axi_bready) begin axi_bvalid = (b_cnt == b_delay); b_cnt++; end
      else begin axi_bvalid = 0; b_cnt = 0; end
      axi_rdata = slave_rdata;
      axi_rresp = slave_resp;
      axi_bresp = slave_resp;
    end
  end

  // ---------------- transaction model ----------------
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];
  logic [35:0] exp_w_q[$];
  logic [32:0] exp_fin_q[$];
  logic [31:0] m1_r = '0;
  logic [31:0] m2_r = '0;

  function automatic void model_fetch(input logic [31:0] addr, input logic [31:0] rdata);
    exp_ar_q.push_back(addr);
    m1_r = rdata;
    exp_fin_q.push_back({1'b0, m1_r});
  endfunction

  function automatic void model_load(input logic [31:0] addr, input logic [31:0] rdata);
    int sh;
    sh = 8 * int'(addr[1:0]);
    exp_ar_q.push_back(addr);
    m2_r = rdata >> sh;
    exp_fin_q.push_back({1'b1, m2_r});
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] w, input logic [3:0] mask);
    int          sh;
    logic [7:0]  strb8;
    logic [31:0] wd;
    sh    = 8 * int'(addr[1:0]);
    strb8 = {4'b0000, mask} << addr[1:0];
    wd    = w << sh;
    exp_aw_q.push_back(addr);
    exp_w_q.push_back({strb8[3:0], wd});
    exp_fin_q.push_back({1'b1, m2_r});
  endfunction

  // ---------------- compare process ----------------
  logic        prev_arv = 0, prev_arr = 0, prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0;
  logic [31:0] prev_araddr = '0, prev_awaddr = '0;
  logic [35:0] prev_w = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (axi_arvalid && axi_arready) begin
        if (exp_ar_q.size() > 0) check("ar_addr", axi_araddr, exp_ar_q.pop_front());
        else check("ar_unexpected", exp_ar_q.size(), 1);
      end
      if (axi_awvalid && axi_awready) begin
        if (exp_aw_q.size() > 0) check("aw_addr", axi_awaddr, exp_aw_q.pop_front());
        else check("aw_unexpected", exp_aw_q.size(), 1);
      end
      if (axi_wvalid && axi_wready) begin
        if (exp_w_q.size() > 0) check("w_strb_data", {axi_wstrb, axi_wdata}, exp_w_q.pop_front());
        else check("w_unexpected", exp_w_q.size(), 1);
      end
      if (mem_1_finish || mem_2_finish) begin
        check("finish_exclusive", {31'd0, mem_1_finish & mem_2_finish}, 0);
        if (exp_fin_q.size() > 0) begin
          logic [32:0] e;
          e = exp_fin_q.pop_front();
          check("finish_port", {63'd0, mem_2_finish}, {63'd0, e[32]});
          check("finish_rdata", mem_2_finish ? mem_2_r : mem_1_r, e[31:0]);
        end else begin
          check("finish_unexpected", exp_fin_q.size(), 1);
        end
      end
      if (axi_arvalid || axi_rready || axi_awvalid || axi_wvalid || axi_bready)
        check("chan_overlap", {63'd0, (axi_arvalid | axi_rready) & (axi_awvalid | axi_wvalid | axi_bready)}, 0);
      if (prev_arv && !prev_arr) check("arvalid_hold", {axi_arvalid, axi_araddr}, {1'b1, prev_araddr});
      if (prev_awv && !prev_awr) check("awvalid_hold", {axi_awvalid, axi_awaddr}, {1'b1, prev_awaddr});
      if (prev_wv && !prev_wr) check("wvalid_hold", {axi_wvalid, axi_wstrb, axi_wdata}, {1'b1, prev_w});
    end
    prev_arv = axi_arvalid; prev_arr = axi_arready; prev_araddr = axi_araddr;
    prev_awv = axi_awvalid; prev_awr = axi_awready; prev_awaddr = axi_awaddr;
    prev_wv  = axi_wvalid;  prev_wr  = axi_wready;  prev_w = {axi_wstrb, axi_wdata};
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic f_en, input logic [31:0] f_addr, input logic l_en, input logic s_en,
                       input logic [31:0] a2, input logic [31:0] w2, input logic [3:0] m2);
    @(negedge clk);
    mem_1_r_en = f_en; mem_1_addr = f_addr;
    mem_2_r_en = l_en; mem_2_w_en = s_en;
    mem_2_addr = a2; mem_2_w = w2; mem_2_mask = m2;
    @(posedge clk);
    #1;
    mem_1_r_en = 0; mem_2_r_en = 0; mem_2_w_en = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (exp_fin_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_timeout"}, exp_fin_q.size(), 0);
    step();
    check({name, "_axi_drained"}, exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size(), 0);
    check({name, "_idle"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 0;
    mem_1_addr = '0; mem_1_r_en = 0;
    mem_2_addr = '0; mem_2_w = '0; mem_2_mask = '0; mem_2_r_en = 0; mem_2_w_en = 0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready,
                            mem_1_finish, mem_2_finish, axi_araddr, axi_awaddr}, 0);
    check("reset_data", {axi_wdata, axi_wstrb, mem_1_r, mem_2_r}, 0);
    check("reset_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1;
    step();

    // Zero-wait fetch: arvalid cycle 1, rready cycle 2, finish cycle 3.
    slave_rdata = 32'h0000_0413;
    model_fetch(32'h8000_0000, 32'h0000_0413);
    drive(1, 32'h8000_0000, 0, 0, '0, '0, '0);
    step();
    check("fetch_c1_arvalid", {axi_arvalid, axi_araddr}, {1'b1, 32'h8000_0000});
    step();
    check("fetch_c2_rready", {axi_arvalid, axi_rready}, 2'b01);
    step();
    check("fetch_c3_finish", {mem_1_finish, mem_1_r}, {1'b1, 32'h0000_0413});
    step();
    check("fetch_c4_pulse_end", {31'd0, mem_1_finish}, 0);
    wait_done("fetch", 20);

    // Byte store at offset 3, bvalid one cycle late.
    b_delay = 1;
    model_store(32'h8000_0103, 32'h0000_00AB, 4'b0001);
    drive(0, '0, 0, 1, 32'h8000_0103, 32'h0000_00AB, 4'b0001);
    step();
    check("bstore_c1_payload", {axi_awvalid, axi_wvalid, axi_wstrb, axi_wdata},
          {1'b1, 1'b1, 4'b1000, 32'hAB00_0000});
    step();
    check("bstore_c2_bready", {axi_bready, axi_bvalid, mem_2_finish}, 3'b100);
    step();
    check("bstore_c3_bvalid", {axi_bvalid, mem_2_finish}, 2'b10);
    step();
    check("bstore_c4_finish", {31'd0, mem_2_finish}, 1);
    wait_done("bstore", 20);
    check("bstore_resp_ok", {31'd0, dbg_resp_err}, 0);
    b_delay = 0;

    // Halfword load, arready held off for three cycles.
    ar_delay = 3;
    slave_rdata = 32'hBEEF_1234;
    model_load(32'h8000_0102, 32'hBEEF_1234);
    drive(0, '0, 1, 0, 32'h8000_0102, '0, '0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("hload_ar_wait", {axi_arvalid, axi_arready, axi_araddr}, {2'b10, 32'h8000_0102});
    end
    step();
    check("hload_ar_hs", {axi_arvalid, axi_arready}, 2'b11);
    wait_done("hload", 20);
    check("hload_value", mem_2_r, 32'h0000_BEEF);
    ar_delay = 0;

    // Fetch and store in the same cycle: store is served first.
    slave_rdata = 32'h0010_0073;
    model_store(32'h8000_0010, 32'h1122_3344, 4'b1111);
    model_fetch(32'h8000_0004, 32'h0010_0073);
    drive(1, 32'h8000_0004, 0, 1, 32'h8000_0010, 32'h1122_3344, 4'b1111);
    step();
    check("dual_c1_write_first", {axi_awvalid, axi_arvalid}, 2'b10);
    wait_done("dual", 40);
    check("dual_fetch_value", mem_1_r, 32'h0010_0073);
    check("dual_load_hold", mem_2_r, 32'h0000_BEEF);

    // awready two cycles behind wready.
    aw_delay = 2;
    model_store(32'h8000_0021, 32'h0000_CAFE, 4'b0011);
    drive(0, '0, 0, 1, 32'h8000_0021, 32'h0000_CAFE, 4'b0011);
    step();
    check("awlate_c1", {axi_awvalid, axi_wvalid, axi_wstrb, axi_wdata}, {2'b11, 4'b0110, 32'h00CA_FE00});
    step();
    check("awlate_c2", {axi_awvalid, axi_wvalid, axi_bready}, 3'b100);
    check("awlate_c2_state", dbg_state, ST_AW);
    step();
    check("awlate_c3", {axi_awvalid, axi_bready}, 2'b10);
    step();
    check("awlate_c4", {axi_awvalid, axi_bready}, 2'b01);
    wait_done("awlate", 20);
    aw_delay = 0;

    // Reset while waiting in R: everything drops, no finish pulse.
    r_delay = 20;
    slave_rdata = 32'h5555_AAAA;
    model_load(32'h8000_0040, 32'h5555_AAAA);
    drive(0, '0, 1, 0, 32'h8000_0040, '0, '0);
    step();
    step();
    check("rst_pre_in_r", {axi_rready, 3'(dbg_state)}, {1'b1, 3'(ST_R)});
    rst = 0;
    #1;
    check("rst_async_drop", {axi_rready, axi_arvalid, mem_2_finish, mem_1_finish}, 0);
    check("rst_async_state", dbg_state, ST_IDLE);
    check("rst_async_rdata", {mem_1_r, mem_2_r}, 0);
    exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_fin_q.delete();
    m1_r = '0; m2_r = '0;
    r_delay = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_after_quiet", {dbg_state, mem_1_finish, mem_2_finish, axi_arvalid}, {ST_IDLE, 3'b000});
    end
    slave_rdata = 32'h0BAD_F00D;
    model_fetch(32'h8000_0044, 32'h0BAD_F00D);
    drive(1, 32'h8000_0044, 0, 0, '0, '0, '0);
    wait_done("rst_restart", 20);
    check("rst_restart_value", mem_1_r, 32'h0BAD_F00D);

    // Load and store pulsed together on port 2: only the store happens.
    model_store(32'h8000_0052, 32'h0000_5A5A, 4'b0011);
    drive(0, '0, 1, 1, 32'h8000_0052, 32'h0000_5A5A, 4'b0011);
    step();
    check("ldst_store_wins", {axi_arvalid, axi_awvalid, axi_wstrb, axi_wdata}, {2'b01, 4'b1100, 32'h5A5A_0000});
    wait_done("ldst", 20);

    // Byte load at offset 3 with SLVERR and slow rvalid.
    r_delay = 2;
    slave_resp = AXI_SLVERR;
    slave_rdata = 32'hDEAD_BEEF;
    model_load(32'h8000_0063, 32'hDEAD_BEEF);
    drive(0, '0, 1, 0, 32'h8000_0063, '0, '0);
    wait_done("slverr", 20);
    check("slverr_value", mem_2_r, 32'h0000_00DE);
    check("slverr_flag", {31'd0, dbg_resp_err}, 1);
    check("slverr_fetch_hold", mem_1_r, 32'h0BAD_F00D);
    slave_resp = AXI_OKAY;
    r_delay = 0;

    // Halfword store at offset 3: upper lane falls off the word.
    model_store(32'h8000_0073, 32'h0000_BBAA, 4'b0011);
    drive(0, '0, 0, 1, 32'h8000_0073, 32'h0000_BBAA, 4'b0011);
    step();
    check("mis_store_payload", {axi_wstrb, axi_wdata, axi_awaddr}, {4'b1000, 32'hAA00_0000, 32'h8000_0073});
    wait_done("mis_store", 20);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
